// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multi-cycle sequencer for the RV32I core.
// Walks each instruction through IDLE/IF/ID/EX/MEM/WB, decodes the opcode
// class from the latched IR, resolves branches from the ALU flags and drives
// the datapath strobes and memory handshakes. Illegal opcodes and memory
// timeouts park the sequencer in TRAP until reset.
module mc_seq_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       Op,
  input  logic [2:0]       Funct3,
  input  logic             zf,
  input  logic             sf,
  input  logic             cf,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             retire,
  output logic             halt,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_TRAP = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_OPIMM,
    CLS_OP
  } cls_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JAL    = 2'b10;
  localparam logic [1:0] NPC_JALR   = 2'b11;

  // Last wait count that may still be served; one more idle cycle means timeout.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     cur;
  logic [7:0] wait_cnt;
  cls_t       cls;
  logic       br_taken;

  // Opcode class from the latched IR; jalr and branch also need a legal funct3.
  always_comb begin
    cls = CLS_ILLEGAL;
    case (Op)
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = (Funct3 == 3'b000) ? CLS_JALR : CLS_ILLEGAL;
      OP_BRANCH: cls = (Funct3 == 3'b010 || Funct3 == 3'b011) ? CLS_ILLEGAL : CLS_BRANCH;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_OPIMM:  cls = CLS_OPIMM;
      OP_OP:     cls = CLS_OP;
      default:   cls = CLS_ILLEGAL;
    endcase
  end

  // Branch condition from the ALU flags; odd funct3 bit inverts the sense.
  always_comb begin
    br_taken = 1'b0;
    case (Funct3)
      3'b000:  br_taken = zf;
      3'b001:  br_taken = ~zf;
      3'b100:  br_taken = sf;
      3'b101:  br_taken = ~sf;
      3'b110:  br_taken = cf;
      3'b111:  br_taken = ~cf;
      default: br_taken = 1'b0;
    endcase
  end

  // Datapath strobes and requests, decoded from the current state and inputs.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;
    npc_sel  = NPC_SEQ;
    retire   = 1'b0;
    halt     = 1'b0;
    case (cur)
      S_IF: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_EX: begin
        if (cls == CLS_BRANCH) begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          npc_sel = br_taken ? NPC_BRANCH : NPC_SEQ;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STORE);
        if (cls == CLS_STORE && dmem_ready) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        if (cls == CLS_JAL)
          npc_sel = NPC_JAL;
        else if (cls == CLS_JALR)
          npc_sel = NPC_JALR;
        else
          npc_sel = NPC_SEQ;
      end
      S_TRAP: begin
        halt = 1'b1;
      end
      default: begin
        halt = 1'b0;
      end
    endcase
  end

  // Sequencer state and memory wait counter; the counter restarts on every state change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur      <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (cur)
        S_IDLE: cur <= S_IF;
        S_IF: begin
          if (imem_ready)
            cur <= S_ID;
          else if (wait_cnt == WAIT_LAST)
            cur <= S_TRAP;
          else
            wait_cnt <= wait_cnt + 8'd1;
        end
        S_ID: cur <= (cls == CLS_ILLEGAL) ? S_TRAP : S_EX;
        S_EX: begin
          if (cls == CLS_BRANCH)
            cur <= S_IF;
          else if (cls == CLS_LOAD || cls == CLS_STORE)
            cur <= S_MEM;
          else
            cur <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready)
            cur <= (cls == CLS_STORE) ? S_IF : S_WB;
          else if (wait_cnt == WAIT_LAST)
            cur <= S_TRAP;
          else
            wait_cnt <= wait_cnt + 8'd1;
        end
        S_WB:   cur <= S_IF;
        S_TRAP: cur <= S_TRAP;
        default: cur <= S_IDLE;
      endcase
    end
  end

  // Retired-instruction counter, wrapping silently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      instret <= '0;
    else if (retire)
      instret <= instret + CNT_W'(1);
  end

  assign state = cur;

endmodule

// File: doc/mc_seq_ctrl.md
Name: mc_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core: steps each instruction through IDLE/IF/ID/EX/MEM/WB.
- Decodes opcode class from the latched IR and evaluates branch conditions from ALU flags.
- Drives write-enables and memory handshakes for the shared datapath (PC, IR, regfile, data memory).
- Halts in TRAP on an illegal opcode or a memory timeout. Keeps a retired-instruction counter.

Parameters:
- WAIT_MAX, 16, maximum cycles a memory request may stay unanswered before TRAP (legal range 2..255).
- CNT_W, 32, width of the instret counter.

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- Op  input  7  opcode field of the latched IR
- Funct3  input  3  funct3 field of the latched IR
- zf  input  1  ALU zero flag, valid in EX
- sf  input  1  ALU signed-less-than flag, valid in EX
- cf  input  1  ALU unsigned-less-than flag, valid in EX
- imem_ready  input  1  instruction memory data valid
- dmem_ready  input  1  data memory access complete
- imem_req  output  1  instruction fetch request
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write (qualifies dmem_req)
- ir_we  output  1  IR load strobe
- reg_we  output  1  register file write strobe
- pc_we  output  1  PC update strobe
- npc_sel  output  2  next-PC select: 00 pc+4, 01 branch target, 10 jal target, 11 jalr target
- retire  output  1  one-cycle pulse per completed instruction
- halt  output  1  high while in TRAP
- state  output  3  current state, for debug
- instret  output  CNT_W  retired instruction count

Behaviour:
- Reset: clk and rstn only; rstn low forces immediately state=IDLE, wait_cnt=0, instret=0. All outputs are 0 while rstn is low.
- State encoding: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, TRAP=6. Code 7 is unreachable and recovers to IDLE.
- Output decoding: all outputs are combinational from state plus the listed inputs. No output is registered except state and instret.
- IDLE: all outputs 0. Goes to IF on the next edge.
- IF: imem_req=1.
  - imem_ready=1: ir_we=1 that cycle, then go to ID.
  - Otherwise wait_cnt increments. When wait_cnt reaches WAIT_MAX-1 with no ready, go to TRAP.
  - wait_cnt clears on every state change.
- ID: classify Op.
  - Legal classes: lui 0110111, auipc 0010111, jal 1101111, jalr 1100111 with f3=000, branch 1100011 with f3 not 010/011, load 0000011, store 0100011, op-imm 0010011, op 0110011.
  - Illegal opcode or funct3 goes to TRAP. Legal goes to EX.
- EX:
  - Branch: pc_we=1. npc_sel=01 if taken, else 00. retire=1. Go to IF.
    - Taken: beq zf, bne ~zf, blt sf, bge ~sf, bltu cf, bgeu ~cf.
  - Load/store: go to MEM.
  - All other legal classes: go to WB.
- MEM: dmem_req=1, dmem_we=1 for store.
  - dmem_ready=1 on a store: pc_we=1, npc_sel=00, retire=1, go to IF.
  - dmem_ready=1 on a load: go to WB.
  - Timeout is the same rule as IF and goes to TRAP.
- WB: reg_we=1, pc_we=1, retire=1, then go to IF.
  - npc_sel: jal=10, jalr=11, all others 00.
- TRAP: halt=1. All strobes and requests are 0. Stays until rstn.
- instret: increments by 1 on every edge where retire=1. Wraps modulo 2^CNT_W with no flag.
- Simultaneity:
  - Ready arriving in the same cycle the timeout threshold is hit counts as ready, with no TRAP.
  - Ready while not requesting is ignored.
- Mid-operation reset: requests drop asynchronously. No pc_we/reg_we pulse may be emitted in the reset cycle.
- Per-instruction cycle counts with zero-wait memory:
  - branch = 3 (IF, ID, EX)
  - store = 4
  - ALU, lui, auipc, jal, jalr = 4
  - load = 5

Test Plan:
- Reset then one R-type add, imem_ready tied 1 → state sequence 0,1,2,3,5,1. reg_we and pc_we high only in WB, npc_sel=00. instret=1 after WB.
- beq with zf=1, then bne with zf=1 → first EX: pc_we=1, npc_sel=01. Second EX: npc_sel=00. Each takes 3 cycles; instret=2.
- lw with dmem_ready delayed 3 cycles → dmem_req high for 4 cycles with dmem_we=0. Then WB: reg_we=1. Total 8 cycles.
- sw with dmem_ready never asserted, WAIT_MAX=16 → TRAP entered 16 cycles after MEM entry. halt=1, no retire, state=6 held for 100 cycles.
- Op=1111111 → TRAP from ID. Also Op=1100011 with f3=010 → TRAP.
- Assert rstn low for 1 cycle while in MEM with dmem_req=1 → dmem_req drops immediately, instret=0. Next is IDLE then IF.
